audio_pcm_unpack: RTL
=====================

AUDIO_PCM_UNPACK -- requirements
Module: audio_pcm_unpack

Interface
REQ-001 SHALL have parameters: RATE_W, 8, width of rate input; RATE_FULL, 128, rate value giving one fetch per sample_tick.
REQ-002 SHALL have ports, in order (clk and rst fixed: one clock; reset asynchronous, active-high):
  clk  input  1  sole clock, rising edge
  rst  input  1  asynchronous active-high reset
  sample_tick  input  1  one-cycle pulse at base sample rate
  rate  input  RATE_W  playback rate step, 0 = stopped
  mode_stereo  input  1  1 = L/R interleaved, 0 = mono
  mode_16bit  input  1  1 = 16-bit little-endian samples, 0 = 8-bit signed
  volume  input  4  linear gain, volume/16 (0 = mute)
  fifo_rddata  input  8  byte from upstream audio FIFO, valid cycle after fifo_rd_en
  fifo_empty  input  1  upstream FIFO empty flag
  fifo_rd_en  output  1  pop one byte from FIFO
  left  output  16  signed left sample, after volume
  right  output  16  signed right sample, after volume
  sample_valid  output  1  one-cycle pulse when left/right update
  underrun  output  1  one-cycle pulse with sample_valid if any byte was missing
  busy  output  1  fetch in progress

Function
REQ-003 SHALL keep a 7-bit phase accumulator; on sample_tick, {carry, phase} = phase + min(rate, RATE_FULL); carry=1 requests a fetch.
REQ-004 SHALL sample mode_stereo and mode_16bit at fetch start and hold them until the fetch completes; changes mid-fetch take effect on the next fetch.
REQ-005 SHALL fetch n bytes per sample: n = 1 (mono 8), 2 (mono 16 or stereo 8), 4 (stereo 16); byte order L-lo, L-hi, R-lo, R-hi (16-bit) or L, R (8-bit).
REQ-006 SHALL use states IDLE -> FETCH -> CAPTURE -> OUTPUT -> IDLE; IDLE->FETCH on tick with carry; FETCH lasts exactly n cycles; CAPTURE one cycle for the final byte; OUTPUT one cycle.
REQ-007 SHALL drive fifo_rd_en = (state==FETCH) & !fifo_empty, one byte slot per FETCH cycle, back-to-back.
REQ-008 SHALL treat a slot with fifo_empty=1 as byte value 0x00 and latch an underrun flag for that sample; byte slot counter advances regardless.
REQ-009 SHALL capture fifo_rddata in the cycle following each asserted fifo_rd_en.
REQ-010 SHALL expand 8-bit samples to {byte, 8'h00}; mono SHALL copy left to right.
REQ-011 SHALL compute output = (sample * volume) >>> 4, signed, full-precision 20-bit product truncated to 16 bits; no overflow possible.
REQ-012 SHALL, for a tick at cycle T with carry, assert fifo_rd_en in T+1..T+n, update left/right and pulse sample_valid in cycle T+n+2, with underrun pulsed in the same cycle if flagged.
REQ-013 SHALL hold left/right between updates; rate=0 produces no fetch and no reads.
REQ-014 SHALL advance the accumulator on a sample_tick arriving while busy but SHALL drop its fetch request; ticks are specified at least 8 cycles apart.
REQ-015 SHALL assert busy in FETCH, CAPTURE and OUTPUT.

Reset
REQ-016 SHALL on rst, asynchronously: state IDLE, phase 0, left 0, right 0, sample_valid 0, underrun 0, busy 0, fifo_rd_en 0.
REQ-017 SHALL on rst asserted mid-fetch abort immediately, discard partial bytes, and issue no further reads; bytes already popped are lost.

Structure
REQ-018 SHALL place state encoding, RATE_FULL and byte-count constants in shared package audio_pkg.
REQ-019 SHALL implement gain in sub-module audio_pcm_volume (16-bit signed x 4-bit unsigned, >>>4), instantiated once per channel.

Verification
REQ-020 Mono 8-bit, rate 128, volume 15, FIFO holds 0x40 -> one read at T+1, left=right=0x3C00 (0x4000*15/16), sample_valid at T+3.
REQ-021 Stereo 16-bit, rate 128, volume 8, bytes 34 12 78 56 -> reads T+1..T+4, left=0x091A, right=0x2B3C, valid at T+6.
REQ-022 Rate 32, 8 ticks -> exactly 2 fetches (ticks 4 and 8); rate 200 -> one fetch per tick.
REQ-023 Stereo 16-bit with only 2 bytes 00 80 queued -> 2 reads, left=0x8000*v/16, right=0, underrun pulse with sample_valid.
REQ-024 rst asserted at T+2 of 4-byte fetch -> fifo_rd_en low same cycle, outputs 0, no sample_valid; next fetch after release reads from current FIFO head.
REQ-025 Tick arriving during busy -> no extra reads, phase advanced, following tick fetches normally.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared constants and types for the PCM unpacker: FSM encoding, rate scale
// and bytes-per-sample for each sample format.
package audio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_OUTPUT  = 2'd3
  } pcm_state_t;

  localparam int PCM_RATE_FULL = 128;
  localparam int PHASE_W       = 7;
  localparam int STEP_W        = PHASE_W + 1;

  localparam logic [2:0] BYTES_MONO8    = 3'd1;
  localparam logic [2:0] BYTES_MONO16   = 3'd2;
  localparam logic [2:0] BYTES_STEREO8  = 3'd2;
  localparam logic [2:0] BYTES_STEREO16 = 3'd4;

  function automatic logic [2:0] bytes_per_sample(input logic stereo, input logic b16);
    logic [2:0] n;
    case ({stereo, b16})
      2'b00:   n = BYTES_MONO8;
      2'b01:   n = BYTES_MONO16;
      2'b10:   n = BYTES_STEREO8;
      default: n = BYTES_STEREO16;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/audio_pcm_volume.sv
// Linear gain stage: signed 16-bit sample times unsigned 4-bit volume, /16.
module audio_pcm_volume (
  input  logic signed [15:0] sample,
  input  logic        [3:0]  volume,
  output logic signed [15:0] scaled
);

  logic signed [20:0] product;

  // Zero-extend volume so the multiply stays signed; |result| < 2^15 after the shift.
  assign product = sample * $signed({1'b0, volume});
  assign scaled  = 16'(product >>> 4);

endmodule

// File: rtl/audio_pcm_unpack.sv
// Rate-driven PCM fetcher: pulls 1..4 bytes per output sample from a byte
// FIFO, assembles left/right words, applies volume and presents them.
module audio_pcm_unpack
  import audio_pkg::*;
#(
  parameter int RATE_W    = 8,
  parameter int RATE_FULL = PCM_RATE_FULL
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_tick,
  input  logic [RATE_W-1:0]        rate,
  input  logic                     mode_stereo,
  input  logic                     mode_16bit,
  input  logic [3:0]               volume,
  input  logic [7:0]               fifo_rddata,
  input  logic                     fifo_empty,
  output logic                     fifo_rd_en,
  output logic signed [15:0]       left,
  output logic signed [15:0]       right,
  output logic                     sample_valid,
  output logic                     underrun,
  output logic                     busy
);

  pcm_state_t          state_reg;
  logic [PHASE_W-1:0]  phase_reg;
  logic [STEP_W-1:0]   step;
  logic [STEP_W-1:0]   phase_sum;
  logic                stereo_reg;
  logic                b16_reg;
  logic [2:0]          nbytes_reg;
  logic [1:0]          slot_reg;
  logic                last_slot;
  logic                pend_valid_reg;
  logic                pend_rd_reg;
  logic [1:0]          pend_slot_reg;
  logic                underrun_flag_reg;
  logic [7:0]          byte_reg  [4];
  logic [7:0]          byte_view [4];
  logic [7:0]          cur_byte;
  logic signed [15:0]  raw       [2];
  logic signed [15:0]  scaled    [2];

  assign step      = (rate >= RATE_W'(RATE_FULL)) ? STEP_W'(RATE_FULL) : STEP_W'(rate);
  assign phase_sum = {1'b0, phase_reg} + step;
  assign last_slot = ({1'b0, slot_reg} == (nbytes_reg - 3'd1));

  assign fifo_rd_en = (state_reg == ST_FETCH) && !fifo_empty;
  assign busy       = (state_reg != ST_IDLE);

  // A slot that saw an empty FIFO contributes 0x00 instead of stale read data.
  assign cur_byte = pend_rd_reg ? fifo_rddata : 8'h00;

  // The last byte arrives in CAPTURE, so it is overlaid combinationally onto
  // the stored bytes to let the gained result register on that same edge.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_view
      assign byte_view[gi] = (pend_valid_reg && (pend_slot_reg == 2'(gi))) ? cur_byte
                                                                          : byte_reg[gi];
    end
  endgenerate

  always_comb begin
    raw[0] = {byte_view[0], 8'h00};
    raw[1] = {byte_view[0], 8'h00};
    case ({stereo_reg, b16_reg})
      2'b00: begin
        raw[0] = {byte_view[0], 8'h00};
        raw[1] = {byte_view[0], 8'h00};
      end
      2'b01: begin
        raw[0] = {byte_view[1], byte_view[0]};
        raw[1] = {byte_view[1], byte_view[0]};
      end
      2'b10: begin
        raw[0] = {byte_view[0], 8'h00};
        raw[1] = {byte_view[1], 8'h00};
      end
      default: begin
        raw[0] = {byte_view[1], byte_view[0]};
        raw[1] = {byte_view[3], byte_view[2]};
      end
    endcase
  end

  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      audio_pcm_volume u_vol (
        .sample (raw[gi]),
        .volume (volume),
        .scaled (scaled[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg         <= ST_IDLE;
      phase_reg         <= '0;
      stereo_reg        <= 1'b0;
      b16_reg           <= 1'b0;
      nbytes_reg        <= 3'd1;
      slot_reg          <= '0;
      pend_valid_reg    <= 1'b0;
      pend_rd_reg       <= 1'b0;
      pend_slot_reg     <= '0;
      underrun_flag_reg <= 1'b0;
      left              <= '0;
      right             <= '0;
      sample_valid      <= 1'b0;
      underrun          <= 1'b0;
      for (int i = 0; i < 4; i++) byte_reg[i] <= '0;
    end else begin
      sample_valid   <= 1'b0;
      underrun       <= 1'b0;
      pend_valid_reg <= 1'b0;
      pend_rd_reg    <= 1'b0;

      // The accumulator always advances; only an idle FSM acts on the carry.
      if (sample_tick) phase_reg <= phase_sum[PHASE_W-1:0];

      if (pend_valid_reg) byte_reg[pend_slot_reg] <= cur_byte;

      case (state_reg)
        ST_IDLE: begin
          if (sample_tick && phase_sum[PHASE_W]) begin
            state_reg         <= ST_FETCH;
            stereo_reg        <= mode_stereo;
            b16_reg           <= mode_16bit;
            nbytes_reg        <= bytes_per_sample(mode_stereo, mode_16bit);
            slot_reg          <= '0;
            underrun_flag_reg <= 1'b0;
          end
        end
        ST_FETCH: begin
          pend_valid_reg <= 1'b1;
          pend_slot_reg  <= slot_reg;
          pend_rd_reg    <= fifo_rd_en;
          if (fifo_empty) underrun_flag_reg <= 1'b1;
          if (last_slot) state_reg <= ST_CAPTURE;
          else           slot_reg  <= slot_reg + 2'd1;
        end
        ST_CAPTURE: begin
          left         <= scaled[0];
          right        <= scaled[1];
          sample_valid <= 1'b1;
          underrun     <= underrun_flag_reg;
          state_reg    <= ST_OUTPUT;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
